alu_rf_seq: RTL

Parametrised successor of the 8-bit ALU/register-file/control-unit core: a WIDTH-bit sequenced datapath that takes two operands and a mode on a Start handshake. It executes a fixed multi-cycle microsequence through an NREG-entry register file and a single-cycle ALU, then presents the result with carry and zero flags and a one-cycle Done pulse. It sits between the top-level operand/switch inputs and the output display, replacing the fixed 8-bit compare/add/subtract controller.

---
 rtl/alu_rf_pkg.sv | 38 +++
 rtl/alu_rf_regfile.sv | 40 ++++
 rtl/alu_rf_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_rf_pkg.sv
// Shared types for the sequenced ALU/register-file datapath: FSM states,
// operand mode codes, ALU operations and fixed register indices.
package alu_rf_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    ADD,
    NEG,
    INC,
    SUB,
    ROT,
    MOVE,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_AUTO = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_SUB  = 2'd2,
    MODE_ROTL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ALU_AND,
    ALU_XOR,
    ALU_ADD,
    ALU_ROTL1
  } alu_op_e;

  localparam int unsigned R0 = 0;
  localparam int unsigned R1 = 1;
  localparam int unsigned R2 = 2;
  localparam int unsigned R3 = 3;

endpackage

// File: rtl/alu_rf_regfile.sv
// NREG x WIDTH register file: one synchronous write port, fixed read taps for
// R0/R1/R2 and one addressed combinational read port for debug.
module alu_rf_regfile
  import alu_rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_waddr,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic [$clog2(NREG)-1:0] i_raddr,
  output logic [WIDTH-1:0]        o_r0,
  output logic [WIDTH-1:0]        o_alu_a,
  output logic [WIDTH-1:0]        o_alu_b,
  output logic [WIDTH-1:0]        o_rdata
);

  localparam int AW = $clog2(NREG);

  logic [WIDTH-1:0] r_mem [NREG];

  // NOTE: every entry is cleared on reset because unused entries must read
  // back as 0; this keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_r0    = r_mem[AW'(R0)];
  assign o_alu_a = r_mem[AW'(R1)];
  assign o_alu_b = r_mem[AW'(R2)];
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_rf_seq.sv
// Sequenced WIDTH-bit datapath: operands are staged through R1/R2, combined by
// a single-cycle ALU over a fixed microsequence, and the result lands in R0.
module alu_rf_seq
  import alu_rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        InA,
  input  logic [WIDTH-1:0]        InB,
  input  logic [1:0]              Mode,
  input  logic                    Start,
  output logic                    Busy,
  output logic                    Done,
  output logic [WIDTH-1:0]        Out,
  output logic                    CO,
  output logic                    Z,
  input  logic [$clog2(NREG)-1:0] RdAdd,
  output logic [WIDTH-1:0]        RdData
);

  localparam int AW = $clog2(NREG);
  localparam int KW = $clog2(WIDTH);

  state_e           r_state;
  mode_e            r_hold_mode;
  logic [WIDTH-1:0] r_hold_a;
  logic [WIDTH-1:0] r_hold_b;
  logic [KW-1:0]    r_cnt;
  logic             r_cs;
  logic             r_co;
  logic             r_z;
  logic             r_busy;
  logic             r_done;

  alu_op_e          w_alu_op;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_c;
  logic             w_alu_zero;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_r0;
  logic [WIDTH-1:0] w_r1;
  logic [WIDTH-1:0] w_r2;
  logic [KW-1:0]    w_k;

  alu_rf_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (RdAdd),
    .o_r0    (w_r0),
    .o_alu_a (w_r1),
    .o_alu_b (w_r2),
    .o_rdata (RdData)
  );

  // Rotate amount is the low log2(WIDTH) bits of the held B operand.
  assign w_k        = r_hold_b[KW-1:0];
  assign w_alu_zero = (w_alu_y == '0);

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_alu_op = ALU_AND;
    w_alu_a  = w_r1;
    w_alu_b  = '1;
    w_we     = 1'b0;
    w_waddr  = AW'(R0);
    w_wdata  = w_alu_y;
    case (r_state)
      LOAD_A: begin w_we = 1'b1; w_waddr = AW'(R1); w_wdata = r_hold_a; end
      LOAD_B: begin w_we = 1'b1; w_waddr = AW'(R2); w_wdata = r_hold_b; end
      CMP: begin
        w_alu_op = ALU_XOR; w_alu_b = w_r2; w_we = 1'b1; w_waddr = AW'(R3);
      end
      ADD, SUB: begin
        w_alu_op = ALU_ADD; w_alu_b = w_r2; w_we = 1'b1; w_waddr = AW'(R0);
      end
      NEG: begin
        w_alu_op = ALU_XOR; w_alu_a = w_r2; w_we = 1'b1; w_waddr = AW'(R2);
      end
      INC: begin
        w_alu_op = ALU_ADD; w_alu_a = w_r2; w_alu_b = WIDTH'(1);
        w_we = 1'b1; w_waddr = AW'(R2);
      end
      ROT:  begin w_alu_op = ALU_ROTL1; w_we = 1'b1; w_waddr = AW'(R1); end
      // A plain move is an AND with all-ones so it still goes through the ALU.
      MOVE: begin w_alu_op = ALU_AND; w_we = 1'b1; w_waddr = AW'(R0); end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_y = '0;
    w_alu_c = 1'b0;
    case (w_alu_op)
      ALU_AND:   w_alu_y = w_alu_a & w_alu_b;
      ALU_XOR:   w_alu_y = w_alu_a ^ w_alu_b;
      ALU_ADD:   {w_alu_c, w_alu_y} = {1'b0, w_alu_a} + {1'b0, w_alu_b};
      ALU_ROTL1: begin
        w_alu_y = {w_alu_a[WIDTH-2:0], w_alu_a[WIDTH-1]};
        w_alu_c = w_alu_a[WIDTH-1];
      end
      default: ;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold_mode <= MODE_AUTO;
      r_hold_a    <= '0;
      r_hold_b    <= '0;
      r_cnt       <= '0;
      r_cs        <= 1'b0;
      r_co        <= 1'b0;
      r_z         <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (Start) begin
          r_hold_a    <= InA;
          r_hold_b    <= InB;
          r_hold_mode <= mode_e'(Mode);
          r_cs        <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= LOAD_A;
        end
        LOAD_A: r_state <= LOAD_B;
        LOAD_B: begin
          r_cnt <= w_k;
          case (r_hold_mode)
            MODE_ADD:  r_state <= ADD;
            MODE_SUB:  r_state <= NEG;
            MODE_ROTL: r_state <= (w_k == '0) ? MOVE : ROT;
            default:   r_state <= CMP;
          endcase
        end
        CMP: r_state <= w_alu_zero ? ADD : NEG;
        ADD: begin
          r_co    <= w_alu_c;
          r_z     <= w_alu_zero;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        NEG: r_state <= INC;
        INC: begin
          r_cs    <= w_alu_c;
          r_state <= SUB;
        end
        // Borrow-free iff either the final add or the +1 of the negate carried.
        SUB: begin
          r_co    <= w_alu_c | r_cs;
          r_z     <= w_alu_zero;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        ROT: begin
          r_cs    <= w_alu_c;
          r_cnt   <= r_cnt - KW'(1);
          r_state <= (r_cnt > KW'(1)) ? ROT : MOVE;
        end
        MOVE: begin
          r_co    <= r_cs;
          r_z     <= w_alu_zero;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign Out  = w_r0;
  assign CO   = r_co;
  assign Z    = r_z;

endmodule
